// File: rtl/dotn_acc_if.sv
// Handshake/operand bundle for dotn_acc.
//   start, acc_in : request and chaining select, sampled on an accepted start
//   v1, v2        : packed signed operand vectors, element i = v[i*W +: W]
//   busy, done    : operation in flight / one-cycle completion pulse
//   result        : signed Q(W-FRAC).FRAC result, held until the next done
//   overflow      : last result was clamped or wrapped, held
// master drives requests (bench / upstream), slave is the accumulator.
interface dotn_acc_if #(
  parameter int unsigned N = 4,
  parameter int unsigned W = 16
);
  logic           start;
  logic           acc_in;
  logic [N*W-1:0] v1;
  logic [N*W-1:0] v2;
  logic           busy;
  logic           done;
  logic [W-1:0]   result;
  logic           overflow;

  modport master (
    output start, acc_in, v1, v2,
    input  busy, done, result, overflow
  );

  modport slave (
    input  start, acc_in, v1, v2,
    output busy, done, result, overflow
  );
endinterface

// File: rtl/dotn_acc.sv
// Sequential N-element signed fixed-point dot product with optional chained accumulation.
// result = (acc_in ? result : 0) + sum(v1[i] * v2[i]), in Q(W-FRAC).FRAC.
// One radix-2 shift-add multiplier is shared across elements; products are summed at full
// precision and rounded/saturated once at the end.
// Ports:
//   clk     : rising-edge clock
//   reset_n : asynchronous active-low reset
//   bus     : dotn_acc_if slave (start/acc_in/v1/v2 in, busy/done/result/overflow out)
module dotn_acc #(
  parameter int unsigned N     = 4,
  parameter int unsigned W     = 16,
  parameter int unsigned FRAC  = 8,
  parameter bit          ROUND = 1'b0,
  parameter bit          SAT   = 1'b1
) (
  input  logic       clk,
  input  logic       reset_n,
  dotn_acc_if.slave  bus
);

  localparam int unsigned AW = 2 * W + $clog2(N) + 2;
  localparam int unsigned EW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned BW = $clog2(W);

  typedef enum logic [1:0] {StIdle, StMul, StAcc, StFin} state_e;

  state_e         state_q;
  logic [N*W-1:0] v1_q, v2_q;   // remaining elements, current-next element at the bottom
  logic [2*W-1:0] mcand_q;      // |a| shifted left once per iteration
  logic [W-1:0]   mplr_q;       // |b| shifted right once per iteration
  logic [2*W-1:0] prod_q;       // unsigned product magnitude
  logic           sign_q;
  logic [BW-1:0]  bit_q;
  logic [EW-1:0]  elem_q;
  logic [AW-1:0]  acc_q;
  logic           busy_q, done_q, overflow_q;
  logic [W-1:0]   result_q;

  function automatic logic [W-1:0] mag(input logic [W-1:0] x);
    // -2^(W-1) maps to 2^(W-1), which still fits W unsigned bits
    return x[W-1] ? (~x + 1'b1) : x;
  endfunction

  logic [2*W-1:0]       prod_signed;
  logic [AW-1:0]        prod_ext, acc_sum, acc_rnd, preload;
  logic signed [AW-1:0] acc_shr;
  logic                 fin_ovf;
  logic [W-1:0]         fin_res;

  always_comb begin
    prod_signed = sign_q ? (~prod_q + 1'b1) : prod_q;
    prod_ext    = {{(AW - 2 * W){prod_signed[2*W-1]}}, prod_signed};
    acc_sum     = acc_q + prod_ext;
    acc_rnd     = ROUND ? (acc_sum + (AW'(1) << (FRAC - 1))) : acc_sum;
    acc_shr     = $signed(acc_rnd) >>> FRAC;
    // In range only if everything above the result sign bit is a copy of it
    fin_ovf     = !((&acc_shr[AW-1:W-1]) || !(|acc_shr[AW-1:W-1]));
    if (fin_ovf && SAT) begin
      fin_res = acc_shr[AW-1] ? {1'b1, {(W - 1){1'b0}}} : {1'b0, {(W - 1){1'b1}}};
    end else begin
      fin_res = acc_shr[W-1:0];
    end
    // Chained mode re-aligns the previous Q-format result to the accumulator's scale
    preload = {{(AW - W){result_q[W-1]}}, result_q} << FRAC;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      v1_q       <= '0;
      v2_q       <= '0;
      mcand_q    <= '0;
      mplr_q     <= '0;
      prod_q     <= '0;
      sign_q     <= 1'b0;
      bit_q      <= '0;
      elem_q     <= '0;
      acc_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      overflow_q <= 1'b0;
      result_q   <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (bus.start) begin
            v1_q    <= bus.v1 >> W;
            v2_q    <= bus.v2 >> W;
            mcand_q <= {{W{1'b0}}, mag(bus.v1[W-1:0])};
            mplr_q  <= mag(bus.v2[W-1:0]);
            sign_q  <= bus.v1[W-1] ^ bus.v2[W-1];
            prod_q  <= '0;
            bit_q   <= '0;
            elem_q  <= '0;
            acc_q   <= bus.acc_in ? preload : '0;
            busy_q  <= 1'b1;
            state_q <= StMul;
          end
        end
        StMul: begin
          if (mplr_q[0]) prod_q <= prod_q + mcand_q;
          mcand_q <= mcand_q << 1;
          mplr_q  <= mplr_q >> 1;
          bit_q   <= bit_q + 1'b1;
          if (bit_q == BW'(W - 1)) state_q <= StAcc;
        end
        StAcc: begin
          acc_q <= acc_sum;
          if (elem_q == EW'(N - 1)) begin
            result_q   <= fin_res;
            overflow_q <= fin_ovf;
            done_q     <= 1'b1;
            state_q    <= StFin;
          end else begin
            elem_q  <= elem_q + 1'b1;
            mcand_q <= {{W{1'b0}}, mag(v1_q[W-1:0])};
            mplr_q  <= mag(v2_q[W-1:0]);
            sign_q  <= v1_q[W-1] ^ v2_q[W-1];
            v1_q    <= v1_q >> W;
            v2_q    <= v2_q >> W;
            prod_q  <= '0;
            bit_q   <= '0;
            state_q <= StMul;
          end
        end
        StFin: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.result   = result_q;
  assign bus.overflow = overflow_q;

endmodule

// File: tb/tb_dotn_acc.sv
// Self-checking bench for dotn_acc: a saturating and a wrapping instance share the stimulus
// and are compared against a plain-arithmetic reference model.
module tb_dotn_acc;
  localparam int unsigned N    = 4;
  localparam int unsigned W    = 16;
  localparam int unsigned FRAC = 8;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [15:0] prev_s = '0;
  logic [15:0] prev_w = '0;

  dotn_acc_if #(.N(N), .W(W)) bus_s ();
  dotn_acc_if #(.N(N), .W(W)) bus_w ();

  dotn_acc #(.N(N), .W(W), .FRAC(FRAC), .ROUND(1'b0), .SAT(1'b1)) u_sat (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus_s)
  );

  dotn_acc #(.N(N), .W(W), .FRAC(FRAC), .ROUND(1'b0), .SAT(1'b0)) u_wrap (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus_w)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [63:0] va, input logic [63:0] vb, input logic acc,
                       input logic st);
    bus_s.v1 = va;  bus_w.v1 = va;
    bus_s.v2 = vb;  bus_w.v2 = vb;
    bus_s.acc_in = acc;  bus_w.acc_in = acc;
    bus_s.start = st;  bus_w.start = st;
  endtask

  function automatic longint dot(input logic [63:0] va, input logic [63:0] vb);
    longint s = 0;
    for (int i = 0; i < 4; i++) begin
      s += longint'($signed(va[i*16 +: 16])) * longint'($signed(vb[i*16 +: 16]));
    end
    return s;
  endfunction

  // {overflow, result} of a full-precision sum scaled by 2^FRAC, truncating toward -inf
  function automatic logic [16:0] fin_val(input longint sum, input bit sat);
    longint     sh;
    logic       ovf;
    logic [15:0] r;
    sh  = sum >>> FRAC;
    ovf = (sh > 32767) || (sh < -32768);
    if (ovf && sat) r = (sh > 0) ? 16'h7FFF : 16'h8000;
    else            r = sh[15:0];
    return {ovf, r};
  endfunction

  // One operation; g1/g2 are busy cycles (1 = cycle after the start edge) at which a
  // competing start with different operands is pulsed.
  task automatic run_op(input string tag, input logic [63:0] va, input logic [63:0] vb,
                        input logic acc, input int g1, input int g2);
    longint      d, sum_s, sum_w;
    logic [16:0] es, ew;
    int          cyc;
    d     = dot(va, vb);
    sum_s = (acc ? longint'($signed(prev_s)) * 256 : 64'sd0) + d;
    sum_w = (acc ? longint'($signed(prev_w)) * 256 : 64'sd0) + d;
    es    = fin_val(sum_s, 1'b1);
    ew    = fin_val(sum_w, 1'b0);
    @(negedge clk);
    drive(va, vb, acc, 1'b1);
    @(posedge clk);
    #1;
    drive(va, vb, acc, 1'b0);
    cyc = 1;
    check({tag, "/busy"}, bus_s.busy, 1);
    while (!bus_s.done && cyc < 200) begin
      if (cyc == g1 || cyc == g2) drive(~va, va ^ vb, ~acc, 1'b1);
      else begin
        bus_s.start = 1'b0;
        bus_w.start = 1'b0;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    bus_s.start = 1'b0;
    bus_w.start = 1'b0;
    check({tag, "/latency"}, cyc, 69);
    check({tag, "/done_w"}, bus_w.done, 1);
    check({tag, "/res_sat"}, bus_s.result, es[15:0]);
    check({tag, "/ovf_sat"}, bus_s.overflow, es[16]);
    check({tag, "/res_wrap"}, bus_w.result, ew[15:0]);
    check({tag, "/ovf_wrap"}, bus_w.overflow, ew[16]);
    prev_s = es[15:0];
    prev_w = ew[15:0];
    @(posedge clk);
    #1;
    check({tag, "/busy_off"}, bus_s.busy, 0);
    check({tag, "/done_off"}, bus_s.done, 0);
  endtask

  localparam logic [63:0] T1A = {16'h0400, 16'h0300, 16'h0200, 16'h0100};
  localparam logic [63:0] T1B = {4{16'h0100}};

  initial begin
    int          cyc;
    int          pulses;
    logic [63:0] va, vb;
    logic [15:0] e;

    drive('0, '0, 1'b0, 1'b0);
    #12;
    check("rst/busy", bus_s.busy, 0);
    check("rst/done", bus_s.done, 0);
    check("rst/result", bus_s.result, 0);
    check("rst/overflow", bus_w.overflow, 0);
    @(negedge clk);
    reset_n = 1'b1;

    run_op("t1", T1A, T1B, 1'b0, 0, 0);
    check("t1/lit", bus_s.result, 16'h0A00);
    run_op("t2_acc", T1A, T1B, 1'b1, 0, 0);
    check("t2_acc/lit", bus_s.result, 16'h1400);
    run_op("t2_clr", T1A, T1B, 1'b0, 0, 0);
    run_op("t3_small", {4{16'h0008}}, {4{16'h0010}}, 1'b0, 0, 0);
    check("t3_small/lit", bus_s.result, 16'h0002);
    run_op("t3_neg", {48'h0, 16'hFF00}, {48'h0, 16'h0080}, 1'b0, 0, 0);
    check("t3_neg/lit", bus_w.result, 16'hFF80);
    run_op("t4_pos", {4{16'h7FFF}}, {4{16'h7FFF}}, 1'b0, 0, 0);
    check("t4_pos/lit_w", bus_w.result, 16'hFC00);
    run_op("t4_neg", {4{16'h8000}}, {4{16'h7FFF}}, 1'b0, 0, 0);
    check("t4_neg/lit_s", bus_s.result, 16'h8000);
    run_op("t4_clear", T1A, T1B, 1'b0, 0, 0);

    // Competing starts while busy, then an immediate back-to-back request
    run_op("t5_busy", T1A, T1B, 1'b0, 5, 68);
    run_op("t5_b2b", {4{16'h0008}}, {4{16'h0010}}, 1'b0, 0, 0);

    for (int k = 0; k < 8; k++) begin
      for (int i = 0; i < 4; i++) begin
        if (k % 2 == 0) begin
          va[i*16 +: 16] = 16'($urandom);
          vb[i*16 +: 16] = 16'($urandom);
        end else begin
          va[i*16 +: 16] = 16'(int'($urandom_range(0, 1023)) - 512);
          vb[i*16 +: 16] = 16'(int'($urandom_range(0, 1023)) - 512);
        end
      end
      run_op($sformatf("rnd%0d", k), va, vb, 1'($urandom_range(0, 1)), 0, 0);
    end

    // Abort mid-operation with an asynchronous reset
    run_op("t6_pre", T1A, T1B, 1'b0, 0, 0);
    @(negedge clk);
    drive(T1A, T1B, 1'b0, 1'b1);
    @(posedge clk);
    #1;
    drive(T1A, T1B, 1'b0, 1'b0);
    cyc = 1;
    while (cyc < 30) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    #2;
    reset_n = 1'b0;
    #1;
    check("t6/busy", bus_s.busy, 0);
    check("t6/done", bus_s.done, 0);
    check("t6/result_s", bus_s.result, 0);
    check("t6/result_w", bus_w.result, 0);
    check("t6/overflow", bus_s.overflow, 0);
    prev_s = '0;
    prev_w = '0;
    repeat (2) @(posedge clk);
    #1;
    check("t6/busy_held", bus_s.busy, 0);
    @(negedge clk);
    reset_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 80; i++) begin
      @(posedge clk);
      #1;
      if (bus_s.done || bus_w.done) pulses++;
    end
    check("t6/no_done", pulses, 0);
    // Chained from the cleared result, so this also shows the result really returned to 0
    run_op("t6_fresh", T1A, T1B, 1'b1, 0, 0);
    e = 16'h0A00;
    check("t6_fresh/lit", bus_s.result, e);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
